// File: rtl/poly_pkg.sv
// Shared constants, queue entry layout and order helpers for the polynomial evaluator.
package poly_pkg;

  localparam int WID_D   = 32;
  localparam int ORD_NUM = 30;
  localparam int CNT_W   = 5;

  typedef struct packed {
    logic [WID_D-1:0] a_left;
    logic [WID_D-1:0] a_right;
    logic [CNT_W-1:0] order_cnt;
  } que_entry_t;

  // True when the order count is the last polynomial order.
  function automatic logic is_final(input logic [CNT_W-1:0] order_cnt);
    return order_cnt == CNT_W'(ORD_NUM - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO with separate level counter and
// sticky overflow flag. A push while full is accepted only if a pop happens
// in the same cycle.
module sync_fifo_fwft #(
  parameter int EW    = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [EW-1:0] wdata,
  input  logic          rdy,
  output logic [EW-1:0] head,
  output logic          vld,
  output logic [AW:0]   level,
  output logic          full,
  output logic          ovf
);

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          pop, push_ok;

  assign vld   = (level_q != '0);
  assign full  = (level_q == (AW+1)'(DEPTH));
  assign level = level_q;
  assign ovf   = ovf_q;
  assign head  = mem_q[rptr_q];

  // Pop/push acceptance and next-state pointers, level and overflow flag.
  always_comb begin
    pop     = vld && rdy;
    push_ok = push && (!full || pop);
    wptr_d  = wptr_q + AW'(push_ok);
    rptr_d  = rptr_q + AW'(pop);
    level_d = level_q + (AW+1)'(push_ok) - (AW+1)'(pop);
    ovf_d   = ovf_q | (push && !push_ok);
  end

  // Control state register; reset discards any push/pop in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage array, no reset; written only on an accepted push.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/eval_queue.sv
// Recirculation queue between ALU and operand arbiter: non-final results are
// requeued with order+1, final-order results leave on the registered result port.
module eval_queue
  import poly_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WID_D-1:0] alu_a_left,
  input  logic [WID_D-1:0] alu_a_right,
  input  logic [CNT_W-1:0] alu_order_cnt,
  input  logic             alu_dt_vld,
  output logic [WID_D-1:0] que_a_left,
  output logic [WID_D-1:0] que_a_right,
  output logic [CNT_W-1:0] que_order_cnt,
  output logic             que_dt_vld,
  input  logic             mux2que_rdy,
  output logic [WID_D-1:0] res_a_left,
  output logic [WID_D-1:0] res_a_right,
  output logic             res_vld,
  output logic [AW:0]      que_level,
  output logic             que_full,
  output logic             ovf_err,
  output logic             ord_err
);

  que_entry_t       push_entry, head_entry;
  logic             push_cand, is_fin, is_bad;
  logic [WID_D-1:0] res_left_q, res_left_d;
  logic [WID_D-1:0] res_right_q, res_right_d;
  logic             res_vld_q, res_vld_d;
  logic             ord_err_q, ord_err_d;

  // Classify the incoming ALU result and build the requeued entry.
  always_comb begin
    is_fin    = alu_dt_vld && is_final(alu_order_cnt);
    push_cand = alu_dt_vld && (alu_order_cnt < CNT_W'(ORD_NUM - 1));
    is_bad    = alu_dt_vld && (alu_order_cnt > CNT_W'(ORD_NUM - 1));
    push_entry.a_left    = alu_a_left;
    push_entry.a_right   = alu_a_right;
    push_entry.order_cnt = alu_order_cnt + CNT_W'(1);
  end

  sync_fifo_fwft #(
    .EW   ($bits(que_entry_t)),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push_cand),
    .wdata(push_entry),
    .rdy  (mux2que_rdy),
    .head (head_entry),
    .vld  (que_dt_vld),
    .level(que_level),
    .full (que_full),
    .ovf  (ovf_err)
  );

  assign que_a_left    = head_entry.a_left;
  assign que_a_right   = head_entry.a_right;
  assign que_order_cnt = head_entry.order_cnt;

  // Result register loads on final order; error flag is sticky.
  always_comb begin
    res_vld_d   = is_fin;
    res_left_d  = is_fin ? alu_a_left  : res_left_q;
    res_right_d = is_fin ? alu_a_right : res_right_q;
    ord_err_d   = ord_err_q | is_bad;
  end

  // Result and error state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_vld_q   <= 1'b0;
      res_left_q  <= '0;
      res_right_q <= '0;
      ord_err_q   <= 1'b0;
    end else begin
      res_vld_q   <= res_vld_d;
      res_left_q  <= res_left_d;
      res_right_q <= res_right_d;
      ord_err_q   <= ord_err_d;
    end
  end

  assign res_vld     = res_vld_q;
  assign res_a_left  = res_left_q;
  assign res_a_right = res_right_q;
  assign ord_err     = ord_err_q;

endmodule

// File: doc/eval_queue.md
Name: eval_queue

Overview:
- Recirculation queue between the ALU output and the operand arbiter in the polynomial evaluator.
- Captures each ALU result pair and its order count.
- Non-final results are buffered with the order count incremented, then replayed to the arbiter as que_* operands under the arbiter's mux2que_rdy backpressure.
- A result at the last order (ORD_NUM-1) leaves on a separate registered result port instead of re-entering the queue.

Parameters:
WID_D, 32, operand data width
ORD_NUM, 30, number of polynomial orders; valid order counts are 0..ORD_NUM-1
CNT_W, 5, order-count width; must satisfy 2**CNT_W >= ORD_NUM
DEPTH, 8, queue entries; power of two, >= 2
AW, 3, log2(DEPTH)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
alu_a_left  in  WID_D  ALU result, left operand
alu_a_right  in  WID_D  ALU result, right operand
alu_order_cnt  in  CNT_W  order count of the ALU result
alu_dt_vld  in  1  ALU result valid; single-cycle push, no backpressure to the ALU
que_a_left  out  WID_D  head entry, left operand to arbiter
que_a_right  out  WID_D  head entry, right operand to arbiter
que_order_cnt  out  CNT_W  head entry order count
que_dt_vld  out  1  head entry valid
mux2que_rdy  in  1  arbiter accepts head this cycle
res_a_left  out  WID_D  final result, left
res_a_right  out  WID_D  final result, right
res_vld  out  1  final result valid, one-cycle pulse
que_level  out  AW+1  current occupancy, 0..DEPTH
que_full  out  1  que_level == DEPTH
ovf_err  out  1  sticky: a push was dropped because the queue was full
ord_err  out  1  sticky: an illegal order count was received

Behaviour:
- Reset (rst=1 at a clk edge):
  - Clears que_dt_vld, res_vld, que_level, que_full, ovf_err, ord_err.
  - Resets read and write pointers to 0.
  - Sets res_a_left and res_a_right to 0.
  - Leaves array contents undefined.
  - Reset asserted mid-operation discards all queued entries. Any push or pop in that same cycle is ignored.
- Classification of each cycle with alu_dt_vld=1:
  - alu_order_cnt < ORD_NUM-1: push candidate. The stored entry is {alu_a_left, alu_a_right, alu_order_cnt+1}. The increment is CNT_W bits wide and cannot overflow in this range.
  - alu_order_cnt == ORD_NUM-1: final. res_a_left/res_a_right are registered and res_vld=1 on the next cycle. The queue is untouched.
  - alu_order_cnt > ORD_NUM-1: entry is dropped and ord_err is set.
- Pop: occurs when que_dt_vld && mux2que_rdy. mux2que_rdy is ignored while que_dt_vld=0.
- Push acceptance: a push is accepted when que_level < DEPTH, or when a pop occurs in the same cycle (full with simultaneous push and pop leaves the level at DEPTH).
- Overflow: a push while full with no pop is dropped, sets ovf_err, and leaves the level unchanged.
- Output timing:
  - que_* is first-word-fall-through: the head is visible combinationally from the array at the read pointer.
  - que_dt_vld = (que_level != 0).
  - A push into an empty queue in cycle N gives que_dt_vld=1 in cycle N+1. There is no same-cycle bypass.
- Data stability: que_a_left, que_a_right and que_order_cnt are don't-care while que_dt_vld=0. While que_dt_vld=1 and no pop occurs, they are stable.
- Simultaneous push and pop at a non-empty level: the level is unchanged, the head advances, and the new entry is appended at the tail.
- Pointers: AW bits, wrap modulo DEPTH. que_level is tracked as a separate counter.
- Sticky errors: ovf_err and ord_err clear only on rst.
- res_vld: 0 on every cycle without a final-order input. res_a_left/res_a_right hold their last value.

Decomposition:
- poly_pkg holds:
  - the constants WID_D, CNT_W and ORD_NUM;
  - the typedef que_entry_t {a_left, a_right, order_cnt};
  - the function is_final(order_cnt).
- One sub-module, sync_fifo_fwft, parameterised on entry width and DEPTH. It provides push/pop, level, full, FWFT head and ovf flag.
- eval_queue adds classification, the order increment, the result register and ord_err.

Test Plan:
- Reset then idle -> que_dt_vld=0, res_vld=0, que_level=0, ovf_err=0, ord_err=0.
- Push {0x11,0x22,cnt=3} with mux2que_rdy=1 -> next cycle que_dt_vld=1 and que_*={0x11,0x22,4}. Popped that cycle; following cycle que_level=0.
- Push cnt=29 (ORD_NUM=30) with {0xAA,0xBB} -> next cycle res_vld=1, res={0xAA,0xBB} for exactly one cycle, que_level stays 0.
- Hold mux2que_rdy=0 and push 9 entries with cnt=0..8 -> que_full=1 after 8, ninth dropped, ovf_err=1. Release rdy -> cnt 1..8 emerge in order.
- While full, push and pop in the same cycle -> que_level stays 8, no ovf_err, and the new entry appears last in drain order.
- Push cnt=31 -> ord_err=1 and no queue or result activity. Assert rst with 3 entries queued -> que_level=0 and errors cleared next cycle.
